// File: rtl/block_scanout.sv
// block_scanout: raster-order block fetcher and 1-bit-per-colour pixel serializer.
// Reads 16-pixel row slices from the block memory screen port and streams pixels.
//
// Ports:
//   clk, rst              screen clock, asynchronous active-high reset
//   frame_start, busy     frame request pulse / frame in progress
//   block_address_b       {bx, line[9:4]} fetch address to block memory
//   qreds_b/qgreens_b/qblues_b  256-bit block planes returned by memory
//   pix_valid, pix_ready  pixel stream handshake
//   pix_r/g/b             pixel colour bits
//   pix_sof/eol/eof       first-of-frame / end-of-line / end-of-frame markers
module block_scanout #(
    parameter int H_BLOCKS = 40,
    parameter int V_BLOCKS = 30,
    parameter int READ_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    output logic         busy,
    output logic [12:0]  block_address_b,
    input  logic [255:0] qreds_b,
    input  logic [255:0] qgreens_b,
    input  logic [255:0] qblues_b,
    output logic         pix_valid,
    input  logic         pix_ready,
    output logic         pix_r,
    output logic         pix_g,
    output logic         pix_b,
    output logic         pix_sof,
    output logic         pix_eol,
    output logic         pix_eof
);

    localparam logic [6:0] BX_LAST   = 7'(H_BLOCKS - 1);
    localparam logic [9:0] LINE_LAST = 10'(V_BLOCKS * 16 - 1);
    localparam logic [3:0] LAT       = 4'(READ_LAT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state;
    logic [6:0]  bx;
    logic [9:0]  line;

    // Fetch in flight and the attributes of the slice it will return
    logic        pend;
    logic [3:0]  lat_cnt;
    logic [3:0]  pend_idx;
    logic        pend_sof;
    logic        pend_eol;
    logic        pend_eof;

    // Back slice buffer
    logic        bk_valid;
    logic [15:0] bk_r;
    logic [15:0] bk_g;
    logic [15:0] bk_b;
    logic        bk_sof;
    logic        bk_eol;
    logic        bk_eof;

    // Front slice buffer, drives the pixel outputs
    logic        fr_valid;
    logic [15:0] fr_r;
    logic [15:0] fr_g;
    logic [15:0] fr_b;
    logic        fr_sof;
    logic        fr_eol;
    logic        fr_eof;
    logic [3:0]  col;

    logic        xfer;
    logic        pop;
    logic        move;
    logic        capture;
    logic        issue;
    logic        f_last;
    logic [6:0]  f_bx;
    logic [9:0]  f_line;
    logic [7:0]  sl_base;

    always_comb begin
        xfer    = fr_valid & pix_ready;
        pop     = xfer & (col == 4'd15);
        move    = bk_valid & (~fr_valid | pop);
        capture = pend & (lat_cnt == 4'd1);
        // The first fetch of a frame is issued from IDLE at coordinate (0,0)
        f_bx    = (state == IDLE) ? 7'd0 : bx;
        f_line  = (state == IDLE) ? 10'd0 : line;
        f_last  = (f_bx == BX_LAST) & (f_line == LINE_LAST);
        issue   = ~pend & (~bk_valid | move)
                & (((state == IDLE) & frame_start) | (state == RUN));
        sl_base = {pend_idx, 4'd0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            bx              <= '0;
            line            <= '0;
            block_address_b <= '0;
            pend            <= 1'b0;
            lat_cnt         <= '0;
            pend_idx        <= '0;
            pend_sof        <= 1'b0;
            pend_eol        <= 1'b0;
            pend_eof        <= 1'b0;
        end else begin
            if (issue) begin
                block_address_b <= {f_bx, f_line[9:4]};
                pend            <= 1'b1;
                lat_cnt         <= LAT;
                pend_idx        <= f_line[3:0];
                pend_sof        <= (f_bx == 7'd0) & (f_line == 10'd0);
                pend_eol        <= (f_bx == BX_LAST);
                pend_eof        <= f_last;
                // Advance raster position; wrapping leaves counters at 0
                if (f_bx == BX_LAST) begin
                    bx   <= '0;
                    line <= f_last ? 10'd0 : f_line + 10'd1;
                end else begin
                    bx   <= f_bx + 7'd1;
                    line <= f_line;
                end
            end else if (pend) begin
                if (capture) begin
                    pend <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue & f_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (xfer & pix_eof) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bk_valid <= 1'b0;
            bk_r     <= '0;
            bk_g     <= '0;
            bk_b     <= '0;
            bk_sof   <= 1'b0;
            bk_eol   <= 1'b0;
            bk_eof   <= 1'b0;
            fr_valid <= 1'b0;
            fr_r     <= '0;
            fr_g     <= '0;
            fr_b     <= '0;
            fr_sof   <= 1'b0;
            fr_eol   <= 1'b0;
            fr_eof   <= 1'b0;
            col      <= '0;
        end else begin
            // A fetch only issues once back is free, so capture never
            // collides with a valid back entry.
            if (capture) begin
                bk_valid <= 1'b1;
                bk_r     <= qreds_b[sl_base +: 16];
                bk_g     <= qgreens_b[sl_base +: 16];
                bk_b     <= qblues_b[sl_base +: 16];
                bk_sof   <= pend_sof;
                bk_eol   <= pend_eol;
                bk_eof   <= pend_eof;
            end else if (move) begin
                bk_valid <= 1'b0;
            end

            if (move) begin
                fr_valid <= 1'b1;
                fr_r     <= bk_r;
                fr_g     <= bk_g;
                fr_b     <= bk_b;
                fr_sof   <= bk_sof;
                fr_eol   <= bk_eol;
                fr_eof   <= bk_eof;
            end else if (pop) begin
                fr_valid <= 1'b0;
            end

            if (pop) begin
                col <= '0;
            end else if (xfer) begin
                col <= col + 4'd1;
            end
        end
    end

    assign pix_valid = fr_valid;
    assign pix_r     = fr_valid & fr_r[col];
    assign pix_g     = fr_valid & fr_g[col];
    assign pix_b     = fr_valid & fr_b[col];
    assign pix_sof   = fr_valid & fr_sof & (col == 4'd0);
    assign pix_eol   = fr_valid & fr_eol & (col == 4'd15);
    assign pix_eof   = fr_valid & fr_eof & (col == 4'd15);

endmodule

// File: tb/tb_block_scanout.sv
// tb_block_scanout: directed bench for block_scanout on a 2x1-block screen.
// Memory model with two-cycle latency; scoreboard of expected pixels.
module tb_block_scanout;

    localparam int H    = 2;
    localparam int V    = 1;
    localparam int RL   = 2;
    localparam int LW   = H * 16;
    localparam int NPIX = H * 16 * V * 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic         pix_ready = 1'b0;
    logic         busy;
    logic [12:0]  block_address_b;
    logic [255:0] qreds_b;
    logic [255:0] qgreens_b;
    logic [255:0] qblues_b;
    logic         pix_valid;
    logic         pix_r;
    logic         pix_g;
    logic         pix_b;
    logic         pix_sof;
    logic         pix_eol;
    logic         pix_eof;

    block_scanout #(
        .H_BLOCKS(H),
        .V_BLOCKS(V),
        .READ_LAT(RL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .busy(busy),
        .block_address_b(block_address_b),
        .qreds_b(qreds_b),
        .qgreens_b(qgreens_b),
        .qblues_b(qblues_b),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_r(pix_r),
        .pix_g(pix_g),
        .pix_b(pix_b),
        .pix_sof(pix_sof),
        .pix_eol(pix_eol),
        .pix_eof(pix_eof)
    );

    always #5 clk = ~clk;

    // Block memory: one register stage on the address, so data is valid
    // two edges after the address changes.
    logic [255:0] red_m [2];
    logic [255:0] grn_m [2];
    logic [255:0] blu_m [2];
    logic [12:0]  addr_d = '0;

    always @(posedge clk) addr_d <= block_address_b;

    assign qreds_b   = red_m[addr_d[6]];
    assign qgreens_b = grn_m[addr_d[6]];
    assign qblues_b  = blu_m[addr_d[6]];

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int xfers  = 0;

    logic [5:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int t = 0; t < NPIX; t++) begin
            int ln;
            int p;
            int bxi;
            int bi;
            ln  = t / LW;
            p   = t % LW;
            bxi = p / 16;
            bi  = (ln % 16) * 16 + (p % 16);
            exp_q.push_back({red_m[bxi][bi], grn_m[bxi][bi], blu_m[bxi][bi],
                             t == 0, p == LW - 1, t == NPIX - 1});
        end
    endtask

    // Transfer monitor: compares each transferred pixel with the scoreboard
    // and checks that outputs hold while stalled.
    logic [5:0] prev_o = '0;
    logic       prev_stall = 1'b0;

    always @(negedge clk) begin
        logic [5:0] o;
        logic [5:0] e;
        o = {pix_r, pix_g, pix_b, pix_sof, pix_eol, pix_eof};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", 32'(o), 32'(prev_o));
            if (pix_valid && pix_ready) begin
                chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'(o), 32'(e));
                end
                xfers++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_o     = o;
        end
    end

    initial begin
        int n;
        int base;
        logic [3:0] pat;

        red_m[0] = '1;
        red_m[1] = '0;
        grn_m[0] = '0;
        grn_m[0][21] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            grn_m[1][k*32 +: 32] = $urandom;
            blu_m[0][k*32 +: 32] = $urandom;
            blu_m[1][k*32 +: 32] = $urandom;
        end
        pat = 4'b1001;

        // Reset and idle
        tick();
        tick();
        chk("reset_outs", 32'({pix_r, pix_g, pix_b, pix_sof, pix_eol, pix_eof}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_valid", 32'(pix_valid), 32'd0);
            chk("idle_addr", 32'(block_address_b), 32'd0);
        end

        // Frame 1: ready held high, latency and sustained rate
        push_frame();
        pix_ready   = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("f1_busy", 32'(busy), 32'd1);
        chk("f1_addr0", 32'(block_address_b), 32'h0000);
        chk("f1_lat0", 32'(pix_valid), 32'd0);
        tick();
        chk("f1_lat1", 32'(pix_valid), 32'd0);
        tick();
        chk("f1_lat2", 32'(pix_valid), 32'd0);
        tick();
        chk("f1_lat3", 32'(pix_valid), 32'd1);
        chk("f1_addr1", 32'(block_address_b), 32'h0040);
        base = xfers;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk("f1_cycles", 32'(n), 32'd512);
        chk("f1_xfers", 32'(xfers - base), 32'd512);
        chk("f1_queue", 32'(exp_q.size()), 32'd0);

        // Frame 2: started the cycle after busy falls, with backpressure
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("f2_busy", 32'(busy), 32'd1);
        base = xfers;
        n = 0;
        while (busy && n < 5000) begin
            pix_ready = pat[n % 4];
            tick();
            n++;
        end
        pix_ready = 1'b1;
        chk("f2_xfers", 32'(xfers - base), 32'd512);
        chk("f2_queue", 32'(exp_q.size()), 32'd0);

        // Frame 3: frame_start pulsed mid-frame must be ignored
        for (int i = 0; i < 5; i++) tick();
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        base = xfers;
        n = 0;
        while (busy && n < 3000) begin
            frame_start = (n == 10);
            tick();
            n++;
        end
        frame_start = 1'b0;
        chk("f3_xfers", 32'(xfers - base), 32'd512);
        chk("f3_queue", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("f3_no_rerun_busy", 32'(busy), 32'd0);
        chk("f3_no_rerun_valid", 32'(pix_valid), 32'd0);
        chk("f3_no_extra", 32'(xfers - base), 32'd512);

        // Frame 4: reset at transfer 100
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        base = xfers;
        n = 0;
        while ((xfers - base) < 100 && n < 1000) begin
            tick();
            n++;
        end
        chk("f4_reach", 32'(xfers - base), 32'd100);
        rst = 1'b1;
        #1;
        chk("f4_rst_valid", 32'(pix_valid), 32'd0);
        chk("f4_rst_busy", 32'(busy), 32'd0);
        chk("f4_rst_addr", 32'(block_address_b), 32'd0);
        exp_q.delete();
        tick();
        tick();
        chk("f4_rst_hold", 32'(xfers - base), 32'd100);
        rst = 1'b0;
        tick();

        // Frame 5: restart after abort
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("f5_busy", 32'(busy), 32'd1);
        chk("f5_addr0", 32'(block_address_b), 32'h0000);
        base = xfers;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        chk("f5_xfers", 32'(xfers - base), 32'd512);
        chk("f5_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/block_scanout.md
Name: block_scanout

Overview:
- Downstream consumer of the block frame memory's screen-read port (port B, clk_b domain).
- Walks the screen in raster order and issues one 13-bit block address per 16-pixel row slice.
- Captures the returned 256-bit red/green/blue block words and serializes them into a 1-bit-per-colour pixel stream with valid/ready handshake.
- Feeds the video timing/output stage.

Parameters:
- H_BLOCKS, 40, screen width in 16-pixel blocks; legal range 1..72.
- V_BLOCKS, 30, screen height in 16-line blocks; legal range 1..64.
- READ_LAT, 2, clk cycles from block_address_b change to valid qX_b data; legal range 1..14.

Ports:
- clk  in  1  screen-side clock; same clock as memory port B.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle pulse requesting one full-frame scan.
- busy  out  1  high from accepted frame_start until the last pixel of the frame is transferred.
- block_address_b  out  13  {bx[6:0], by[5:0]} block coordinate sent to the memory.
- qreds_b  in  256  red plane of the addressed block.
- qgreens_b  in  256  green plane of the addressed block.
- qblues_b  in  256  blue plane of the addressed block.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts pixel.
- pix_r  out  1  red bit of the current pixel.
- pix_g  out  1  green bit of the current pixel.
- pix_b  out  1  blue bit of the current pixel.
- pix_sof  out  1  current pixel is the first pixel of the frame.
- pix_eol  out  1  current pixel is the last pixel of a screen line.
- pix_eof  out  1  current pixel is the last pixel of the frame.

Behaviour:
- Reset, asynchronous: busy=0, pix_valid=0, pix_r/g/b=0, sof/eol/eof=0, block_address_b=0. Fetch pipeline and both slice buffers are emptied; counters are cleared. Reset mid-frame aborts the frame; no pixel is transferred after rst rises.
- Block layout: pixel (col c, row r) of a block is bit r*16+c of each plane. Pixels within a slice are output c=0..15.
- Frame counters: line 0..V_BLOCKS*16-1 and bx 0..H_BLOCKS-1.
  - Fetch address = {bx, line[9:4]}; captured slice index = line[3:0].
  - Raster order: bx increments per fetch; at bx=H_BLOCKS-1 it wraps to 0 and line increments.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: frame_start=1 moves to RUN, sets busy=1 and loads counters to 0.
  - RUN: issues fetches until the last block of the last line has been issued, then moves to DRAIN.
  - DRAIN: when the eof pixel transfers, moves to IDLE; busy falls on the same edge.
  - frame_start in RUN or DRAIN is ignored.
- Fetch engine:
  - One fetch in flight at most.
  - A fetch issues when the back buffer is empty, or will empty this cycle, and no fetch is pending.
  - block_address_b is registered. It updates on the issuing edge and holds until the next issue.
  - The READ_LAT-cycle counter runs from the issuing edge. On its expiry edge the engine captures qX_b[idx*16 +: 16] for all three planes, plus sof/eol/eof flags, into the back buffer.
- Slice buffers: two entries, front and back.
  - The front entry drives outputs.
  - When the back entry is valid and the front is empty or popping, the back moves to front on the same edge, so there is no bubble.
- Output and handshake:
  - pix_valid = front valid.
  - A transfer occurs when pix_valid & pix_ready; col increments 0..15. At col 15 the front entry pops.
  - While pix_valid & !pix_ready, all pix_* outputs hold stable.
  - pix_sof is high only at col 0 of the first slice of the frame.
  - pix_eol is high at col 15 of the slice with bx=H_BLOCKS-1.
  - pix_eof = pix_eol on the last line.
- Latency: frame_start is sampled at edge E0 and the first address is driven after E0. The first slice is captured at E0+READ_LAT; pix_valid is high after edge E0+READ_LAT+1.
- Throughput: with pix_ready held at 1, output is 1 pixel/clk sustained with no gaps until eof, because READ_LAT+1 ≤ 16.
- Total transfers per frame = H_BLOCKS*16 * V_BLOCKS*16.

Test Plan:
- Reset then idle, 20 cycles with no frame_start -> busy=0, pix_valid=0, block_address_b=0 throughout.
- Small frame (H_BLOCKS=2, V_BLOCKS=1, READ_LAT=2), block (0,0) red=all 1s, block (1,0) red=0, pix_ready=1.
  - pix_valid rises 3 cycles after frame_start; exactly 512 transfers, no gaps.
  - Pixels 0-15 have r=1; pixels 16-31 have r=0.
  - eol appears on transfers 31, 63, ... 511; sof only on transfer 0; eof only on transfer 511.
  - Address sequence: 0x0000, 0x0040, 0x0000, 0x0040 ...
- Bit ordering: block (0,0) green has only bit 1*16+5=21 set -> line 1 shows g=1 only at pixel 5; every other line has g=0.
- Backpressure: pix_ready toggles 1,0,0,1 repeatedly -> no pixel lost or duplicated; outputs stable while stalled; total transfers = 512; only 2 slices buffered ahead.
- frame_start pulsed at cycle 10 of a busy frame -> ignored; exactly one frame is emitted.
- A second frame_start in the cycle after busy falls -> new frame with sof.
- rst asserted mid-frame at transfer 100 -> pix_valid=0 and busy=0 immediately.
- A following frame_start -> restarts at address 0x0000 with sof on its first pixel.
